// File: rtl/rv_sync_fifo_pkg.sv
// rv_sync_fifo_pkg: shared defaults and pointer-width helper for the valid/ready FIFO.
package rv_sync_fifo_pkg;
    localparam int RV_FIFO_DEPTH_DEF = 4;
    localparam int RV_FIFO_WIDTH_DEF = 22;
    function automatic int rv_ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/rv_fifo_entry.sv
// rv_fifo_entry: one FIFO storage word, an enabled async-reset register.
module rv_fifo_entry #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) data_q <= '0;
        else if (en) data_q <= din;
    assign dout = data_q;
endmodule

// File: rtl/rv_sync_fifo.sv
// rv_sync_fifo: same-clock valid/ready FIFO with per-entry storage, registered
// occupancy and a sticky overflow monitor; no fall-through on empty.
module rv_sync_fifo
    import rv_sync_fifo_pkg::*;
#(
    parameter int WIDTH = RV_FIFO_WIDTH_DEF,
    parameter int DEPTH = RV_FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf_err
);
    localparam int PW = rv_ptr_w(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic ovf_q, ovf_d;
    logic push, pop;
    logic [WIDTH-1:0] mem [DEPTH];
    // Handshake outputs come only from state, so neither side sees the other combinationally.
    assign wr_ready = count_q != CW'(DEPTH);
    assign rd_valid = count_q != '0;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + CW'(1) :
                   (pop && !push) ? count_q - CW'(1) : count_q;
        ovf_d    = ovf_q || (wr_valid && !wr_ready && !rd_ready);
    end
    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rv_fifo_entry #(.WIDTH(WIDTH)) u_entry (
            .clk  (clk),
            .rst_l(rst_l),
            .en   (push && wr_ptr_q == PW'(g)),
            .din  (wr_data),
            .dout (mem[g])
        );
    end
    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;
    assign ovf_err = ovf_q;
endmodule

// File: tb/tb_rv_sync_fifo.sv
// tb_rv_sync_fifo: directed self-checking bench for rv_sync_fifo (WIDTH=22, DEPTH=4).
module tb_rv_sync_fifo;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [21:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [21:0] rd_data;
    logic [2:0]  count;
    logic        ovf_err;
    int total = 0;
    int bad = 0;

    rv_sync_fifo #(.WIDTH(22), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data (wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data (rd_data),
        .count   (count),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] w(input int i);
        return 22'h2A0000 | 22'(i);
    endfunction

    logic [21:0] fill [4];

    initial begin
        fill[0] = 22'h3FFFFF; fill[1] = 22'h000001; fill[2] = 22'h155555; fill[3] = 22'h2AAAAA;
        tick(); tick();
        rst_l = 1'b1;
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        // empty: no fall-through
        wr_valid = 1'b1; wr_data = 22'h0ABCDE;
        #1;
        chk("nft_before_valid", 32'(rd_valid), 32'd0);
        tick();
        wr_valid = 1'b0;
        chk("nft_after_valid", 32'(rd_valid), 32'd1);
        chk("nft_after_data", 32'(rd_data), 32'h0ABCDE);
        chk("nft_count", 32'(count), 32'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("nft_pop_count", 32'(count), 32'd0);
        chk("nft_pop_valid", 32'(rd_valid), 32'd0);
        // fill
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = fill[i];
            tick();
        end
        wr_valid = 1'b0;
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_head", 32'(rd_data), 32'h3FFFFF);
        // overflow monitor
        wr_valid = 1'b1; wr_data = 22'h123456;
        #1;
        chk("ovf_before", 32'(ovf_err), 32'd0);
        tick();
        wr_valid = 1'b0;
        chk("ovf_set", 32'(ovf_err), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", 32'(rd_data), 32'h3FFFFF);
        // drain
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(rd_data), 32'(fill[i]));
            tick();
            chk("drain_count", 32'(count), 32'(3 - i));
        end
        rd_ready = 1'b0;
        chk("drain_empty", 32'(rd_valid), 32'd0);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        // simultaneous push/pop at count=2
        wr_valid = 1'b1;
        wr_data = 22'h011111; tick();
        wr_data = 22'h022222; tick();
        wr_data = 22'h033333; rd_ready = 1'b1;
        #1;
        chk("sim_head", 32'(rd_data), 32'h011111);
        tick();
        wr_valid = 1'b0;
        chk("sim_count", 32'(count), 32'd2);
        chk("sim_data1", 32'(rd_data), 32'h022222);
        tick();
        chk("sim_data2", 32'(rd_data), 32'h033333);
        tick();
        rd_ready = 1'b0;
        chk("sim_empty", 32'(count), 32'd0);
        // full with pop and wr_valid: pop only
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 22'h100000 | 22'(i);
            tick();
        end
        wr_data = 22'h1FFFFF; rd_ready = 1'b1;
        #1;
        chk("fp_wr_ready_before", 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0;
        chk("fp_count", 32'(count), 32'd3);
        chk("fp_wr_ready_after", 32'(wr_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            chk("fp_drain", 32'(rd_data), 32'(22'h100000 | 22'(i)));
            tick();
        end
        rd_ready = 1'b0;
        chk("fp_empty", 32'(count), 32'd0);
        // wrap-around: 10 pushes, 10 pops, count held at 1 mid-stream
        wr_valid = 1'b1; wr_data = w(0);
        tick();
        for (int i = 1; i < 10; i++) begin
            wr_data = w(i); rd_ready = 1'b1;
            #1;
            chk("wrap_valid", 32'(rd_valid), 32'd1);
            chk("wrap_data", 32'(rd_data), 32'(w(i - 1)));
            tick();
            chk("wrap_count", 32'(count), 32'd1);
        end
        wr_valid = 1'b0;
        chk("wrap_last", 32'(rd_data), 32'(w(9)));
        tick();
        rd_ready = 1'b0;
        chk("wrap_empty", 32'(count), 32'd0);
        // async reset mid-stream with count=3
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 22'h0C0C00 | 22'(i + 1);
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 rst_l = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_ovf", 32'(ovf_err), 32'd0);
        rd_ready = 1'b1;
        tick();
        chk("rst_hold_count", 32'(count), 32'd0);
        wr_valid = 1'b0; rd_ready = 1'b0;
        rst_l = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_valid", 32'(rd_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
